// File: rtl/aes_pkg.sv
// Shared AES constants and word helpers for the key-schedule datapath.
package aes_pkg;

    localparam int AES_NR = 10;

    typedef enum logic [1:0] {IDLE, EXPAND, SERVE, HOLD} ks_state_t;

    // Round constant for round idx, placed in the most significant byte.
    function automatic logic [31:0] rcon(input logic [3:0] idx);
        logic [7:0] b;
        case (idx)
            4'd1:    b = 8'h01;
            4'd2:    b = 8'h02;
            4'd3:    b = 8'h04;
            4'd4:    b = 8'h08;
            4'd5:    b = 8'h10;
            4'd6:    b = 8'h20;
            4'd7:    b = 8'h40;
            4'd8:    b = 8'h80;
            4'd9:    b = 8'h1b;
            4'd10:   b = 8'h36;
            default: b = 8'h00;
        endcase
        return {b, 24'h000000};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] xor_word(input logic [31:0] a, input logic [31:0] b);
        return a ^ b;
    endfunction

endpackage

// File: rtl/aes_inv_key_schedule_if.sv
// Key-load and round-key delivery signals of the inverse key schedule.
interface aes_inv_key_schedule_if;

    logic         IN_valid;
    logic [127:0] IN_key;
    logic         IN_replay;
    logic         OUT_ready;
    logic         OUT_valid;
    logic [127:0] OUT_key;
    logic [3:0]   OUT_round;
    logic         busy;

    modport master (
        output IN_valid, IN_key, IN_replay, OUT_ready,
        input  OUT_valid, OUT_key, OUT_round, busy
    );

    modport slave (
        input  IN_valid, IN_key, IN_replay, OUT_ready,
        output OUT_valid, OUT_key, OUT_round, busy
    );

endinterface

// File: rtl/aes_sub_word.sv
// Combinational SubWord: four forward AES S-box lookups, one per byte.
module aes_sub_word (
    input  logic [31:0] word,
    output logic [31:0] subst
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            assign subst[gi*8 +: 8] = SBOX[word[gi*8 +: 8]];
        end
    endgenerate

endmodule

// File: rtl/aes_inv_key_schedule.sv
// AES-128 decrypt round-key source: expands forward to K10 once, then
// walks back K10..K0 one key per accepted transfer via inverse expansion.
module aes_inv_key_schedule
    import aes_pkg::*;
#(
    parameter int NR    = AES_NR,
    parameter int KEY_W = 128
) (
    input logic                  clk,
    input logic                  reset_n,
    aes_inv_key_schedule_if.slave ks
);

    localparam logic [3:0] LAST_RND = 4'(NR);

    ks_state_t        state_reg;
    logic [KEY_W-1:0] key_reg;
    logic [KEY_W-1:0] k10_reg;
    logic [3:0]       rnd_reg;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] v0, v1, v2, v3;
    logic [31:0] f0, f1, f2, f3;
    logic [31:0] sub_sel, sub_out;
    logic [KEY_W-1:0] key_fwd_next, key_inv_next;

    assign w0 = key_reg[127:96];
    assign w1 = key_reg[95:64];
    assign w2 = key_reg[63:32];
    assign w3 = key_reg[31:0];

    assign v3 = xor_word(w3, w2);
    assign v2 = xor_word(w2, w1);
    assign v1 = xor_word(w1, w0);

    // One SubWord serves both directions: w3 while expanding, v3 while serving.
    assign sub_sel = (state_reg == SERVE) ? v3 : w3;

    aes_sub_word u_sub_word (
        .word  (rot_word(sub_sel)),
        .subst (sub_out)
    );

    assign f0 = w0 ^ sub_out ^ rcon(rnd_reg + 4'd1);
    assign f1 = xor_word(w1, f0);
    assign f2 = xor_word(w2, f1);
    assign f3 = xor_word(w3, f2);
    assign v0 = w0 ^ sub_out ^ rcon(rnd_reg);

    assign key_fwd_next = {f0, f1, f2, f3};
    assign key_inv_next = {v0, v1, v2, v3};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            key_reg   <= '0;
            k10_reg   <= '0;
            rnd_reg   <= '0;
        end else if (ks.IN_valid) begin
            key_reg   <= ks.IN_key;
            rnd_reg   <= '0;
            state_reg <= EXPAND;
        end else begin
            case (state_reg)
                EXPAND: begin
                    key_reg <= key_fwd_next;
                    rnd_reg <= rnd_reg + 4'd1;
                    if (rnd_reg == LAST_RND - 4'd1) begin
                        k10_reg   <= key_fwd_next;
                        state_reg <= SERVE;
                    end
                end
                SERVE: begin
                    if (ks.OUT_ready) begin
                        if (rnd_reg != 4'd0) begin
                            key_reg <= key_inv_next;
                            rnd_reg <= rnd_reg - 4'd1;
                        end else begin
                            // Rewind to K10 so a replay needs no re-expansion.
                            key_reg   <= k10_reg;
                            rnd_reg   <= LAST_RND;
                            state_reg <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (ks.IN_replay) begin
                        state_reg <= SERVE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ks.OUT_valid = (state_reg == SERVE);
    assign ks.busy      = (state_reg == EXPAND) || (state_reg == SERVE);
    assign ks.OUT_key   = key_reg;
    assign ks.OUT_round = rnd_reg;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Directed bench for the AES-128 inverse key schedule using FIPS-197 key vectors.
module tb_aes_inv_key_schedule;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    aes_inv_key_schedule_if ks_if ();

    aes_inv_key_schedule dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ks      (ks_if)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY2_K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    localparam logic [127:0] KEY1_RK [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        $display("[%0t] %s observed=%h expected=%h", $time, tag, obs, exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [127:0] key, input logic replay);
        ks_if.IN_key    = key;
        ks_if.IN_valid  = 1'b1;
        ks_if.IN_replay = replay;
        tick();
        ks_if.IN_valid  = 1'b0;
        ks_if.IN_replay = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (ks_if.OUT_valid !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 128'(ks_if.OUT_valid), 128'd0);
        chk({tag, "_key"},   ks_if.OUT_key,          128'd0);
        chk({tag, "_round"}, 128'(ks_if.OUT_round), 128'd0);
        chk({tag, "_busy"},  128'(ks_if.busy),      128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int stalls;

        ks_if.IN_valid  = 1'b0;
        ks_if.IN_key    = '0;
        ks_if.IN_replay = 1'b0;
        ks_if.OUT_ready = 1'b0;

        // Reset state
        #2;
        chk_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Key 1 with random stalls: latency, full K10..K0 sequence, stability
        load(KEY1, 1'b0);
        chk("k1_busy_expand", 128'(ks_if.busy), 128'd1);
        wait_valid(n);
        chk("k1_latency", 128'(n), 128'd10);
        for (int r = 10; r >= 0; r--) begin
            stalls = int'($urandom_range(0, 5));
            for (int s = 0; s < stalls; s++) begin
                ks_if.OUT_ready = 1'b0;
                tick();
                chk($sformatf("k1_stall_key_r%0d", r),   ks_if.OUT_key,          KEY1_RK[r]);
                chk($sformatf("k1_stall_round_r%0d", r), 128'(ks_if.OUT_round), 128'(r));
            end
            chk($sformatf("k1_valid_r%0d", r), 128'(ks_if.OUT_valid), 128'd1);
            chk($sformatf("k1_key_r%0d", r),   ks_if.OUT_key,          KEY1_RK[r]);
            chk($sformatf("k1_round_r%0d", r), 128'(ks_if.OUT_round), 128'(r));
            ks_if.OUT_ready = 1'b1;
            tick();
            ks_if.OUT_ready = 1'b0;
        end
        chk("k1_hold_valid", 128'(ks_if.OUT_valid), 128'd0);
        chk("k1_hold_busy",  128'(ks_if.busy),      128'd0);

        // Key 2, ready held: 11 keys on consecutive cycles
        ks_if.OUT_ready = 1'b1;
        load(KEY2, 1'b0);
        wait_valid(n);
        chk("k2_latency", 128'(n), 128'd10);
        chk("k2_k10", ks_if.OUT_key, KEY2_K10);
        for (int i = 0; i <= 10; i++) begin
            chk($sformatf("k2_valid_%0d", i), 128'(ks_if.OUT_valid), 128'd1);
            chk($sformatf("k2_round_%0d", i), 128'(ks_if.OUT_round), 128'(10 - i));
            if (i == 10) chk("k2_k0", ks_if.OUT_key, KEY2);
            tick();
        end
        ks_if.OUT_ready = 1'b0;
        chk("k2_hold_valid", 128'(ks_if.OUT_valid), 128'd0);
        chk("k2_hold_busy",  128'(ks_if.busy),      128'd0);

        // Replay from HOLD, then replay ignored in SERVE
        ks_if.IN_replay = 1'b1;
        tick();
        ks_if.IN_replay = 1'b0;
        chk("replay_valid", 128'(ks_if.OUT_valid), 128'd1);
        chk("replay_key",   ks_if.OUT_key,          KEY2_K10);
        chk("replay_round", 128'(ks_if.OUT_round), 128'd10);
        ks_if.IN_replay = 1'b1;
        tick();
        ks_if.IN_replay = 1'b0;
        chk("replay_serve_round", 128'(ks_if.OUT_round), 128'd10);
        chk("replay_serve_key",   ks_if.OUT_key,          KEY2_K10);
        ks_if.OUT_ready = 1'b1;
        repeat (4) tick();
        ks_if.OUT_ready = 1'b0;
        chk("serve_round6", 128'(ks_if.OUT_round), 128'd6);

        // Abort at round 6 with IN_valid+IN_replay and a pending transfer
        ks_if.OUT_ready = 1'b1;
        load(KEY1, 1'b1);
        ks_if.OUT_ready = 1'b0;
        chk("abort_valid", 128'(ks_if.OUT_valid), 128'd0);
        chk("abort_busy",  128'(ks_if.busy),      128'd1);
        chk("abort_key",   ks_if.OUT_key,          KEY1);
        chk("abort_round", 128'(ks_if.OUT_round), 128'd0);
        wait_valid(n);
        chk("abort_latency", 128'(n), 128'd10);
        chk("abort_k10",     ks_if.OUT_key, KEY1_RK[10]);

        // Async reset in SERVE
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("rst_serve");
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        ks_if.IN_replay = 1'b1;
        tick();
        ks_if.IN_replay = 1'b0;
        repeat (3) tick();
        chk("rst_serve_replay_valid", 128'(ks_if.OUT_valid), 128'd0);
        chk("rst_serve_replay_busy",  128'(ks_if.busy),      128'd0);

        // Async reset in EXPAND
        load(KEY2, 1'b0);
        repeat (3) tick();
        chk("rst_expand_busy_pre", 128'(ks_if.busy), 128'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("rst_expand");
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        ks_if.IN_replay = 1'b1;
        tick();
        ks_if.IN_replay = 1'b0;
        chk("rst_expand_replay_valid", 128'(ks_if.OUT_valid), 128'd0);

        // Recovery after reset
        load(KEY1, 1'b0);
        wait_valid(n);
        chk("recover_latency", 128'(n), 128'd10);
        chk("recover_k10",     ks_if.OUT_key, KEY1_RK[10]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
